// File: rtl/othello_pkg.sv
// Shared Othello board/plotter definitions: cell codes, plotter select codes,
// board geometry and the draw-sequencer state encoding.
package othello_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;
  localparam logic [1:0] CELL_RSVD  = 2'b11;

  localparam logic [1:0] SEL_EMPTY  = 2'b00;
  localparam logic [1:0] SEL_CURSOR = 2'b01;
  localparam logic [1:0] SEL_BLACK  = 2'b10;
  localparam logic [1:0] SEL_WHITE  = 2'b11;

  localparam int BOARD_DIM = 8;
  localparam int CELL_PX   = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_GAP      = 3'd2,
    ST_FIRE     = 3'd3,
    ST_OVL_LOAD = 3'd4,
    ST_DONE     = 3'd5
  } seq_state_e;

endpackage

// File: rtl/cell_select_decode.sv
// Maps a 2-bit board cell code to the plotter select code.
// Shared with the game-logic debug view.
module cell_select_decode
  import othello_pkg::*;
(
  input  logic [1:0] cell_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = SEL_EMPTY;
    case (cell_i)
      CELL_BLACK: sel_o = SEL_BLACK;
      CELL_WHITE: sel_o = SEL_WHITE;
      CELL_EMPTY,
      CELL_RSVD:  sel_o = SEL_EMPTY;
      default:    sel_o = SEL_EMPTY;
    endcase
  end

endmodule

// File: rtl/board_draw_sequencer.sv
// Snapshots the board and cursor on a redraw request, then paces 64 cell passes
// plus one cursor-overlay pass into the cell plotter using a fixed cycle budget.
//
// state    | meaning
// IDLE     | waiting for start (or a pending request); captures snapshot
// LOAD     | latch x/y/select for cell idx
// GAP      | draw_en low so the plotter re-arms its edge detector
// FIRE     | draw_en high for one plotter sweep
// OVL_LOAD | latch cursor coordinates with the overlay select
// DONE     | one-cycle done pulse
module board_draw_sequencer
  import othello_pkg::*;
#(
  parameter logic [7:0] X_ORIGIN    = 8'd16,
  parameter logic [6:0] Y_ORIGIN    = 7'd12,
  parameter int         CELL_PITCH  = 12,
  parameter int         CELL_CYCLES = 150,
  parameter int         GAP_CYCLES  = 2
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         start,
  input  logic [127:0] board,
  input  logic [2:0]   cursor_row,
  input  logic [2:0]   cursor_col,
  output logic [7:0]   x_out,
  output logic [6:0]   y_out,
  output logic [1:0]   select,
  output logic         draw_en,
  output logic         busy,
  output logic         done
);

  localparam int X_LAST = int'(X_ORIGIN) + (BOARD_DIM - 1) * CELL_PITCH + CELL_PX - 1;
  localparam int Y_LAST = int'(Y_ORIGIN) + (BOARD_DIM - 1) * CELL_PITCH + CELL_PX - 1;

  if (CELL_CYCLES < 146 || CELL_CYCLES > 256 || GAP_CYCLES < 1 || GAP_CYCLES > 256 ||
      X_LAST > 159 || Y_LAST > 119) begin : g_bad_params
    $error("board_draw_sequencer: illegal timing or geometry parameters");
  end

  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] FIRE_LOAD = 8'(CELL_CYCLES - 1);

  seq_state_e   state_q, state_d;
  logic [5:0]   idx_q, idx_d;
  logic [7:0]   timer_q, timer_d;
  logic [127:0] board_q, board_d;
  logic [2:0]   crow_q, crow_d, ccol_q, ccol_d;
  logic         pending_q, pending_d;
  logic         overlay_q, overlay_d;
  logic         busy_q, busy_d;
  logic [7:0]   x_q, x_d;
  logic [6:0]   y_q, y_d;
  logic [1:0]   sel_q, sel_d;

  logic [2:0]   pass_row, pass_col;
  logic [7:0]   row_px, col_px;
  logic [1:0]   cell_code, cell_sel;

  assign cell_code = board_q[{idx_q, 1'b0} +: 2];

  cell_select_decode u_decode (
    .cell_i (cell_code),
    .sel_o  (cell_sel)
  );

  assign pass_row = (state_q == ST_OVL_LOAD) ? crow_q : idx_q[5:3];
  assign pass_col = (state_q == ST_OVL_LOAD) ? ccol_q : idx_q[2:0];
  assign row_px   = {5'd0, pass_row} * 8'(CELL_PITCH);
  assign col_px   = {5'd0, pass_col} * 8'(CELL_PITCH);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    board_d   = board_q;
    crow_d    = crow_q;
    ccol_d    = ccol_q;
    pending_d = pending_q;
    overlay_d = overlay_q;
    busy_d    = busy_q;
    x_d       = x_q;
    y_d       = y_q;
    sel_d     = sel_q;

    // Requests arriving mid-frame (including DONE) collapse into one pending frame.
    if (state_q != ST_IDLE && start) pending_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start || pending_q) begin
          board_d   = board;
          crow_d    = cursor_row;
          ccol_d    = cursor_col;
          idx_d     = '0;
          overlay_d = 1'b0;
          pending_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD, ST_OVL_LOAD: begin
        x_d       = X_ORIGIN + col_px;
        y_d       = Y_ORIGIN + row_px[6:0];
        sel_d     = (state_q == ST_OVL_LOAD) ? SEL_CURSOR : cell_sel;
        overlay_d = (state_q == ST_OVL_LOAD);
        timer_d   = GAP_LOAD;
        state_d   = ST_GAP;
      end
      ST_GAP: begin
        if (timer_q == '0) begin
          timer_d = FIRE_LOAD;
          state_d = ST_FIRE;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      ST_FIRE: begin
        if (timer_q == '0) begin
          if (overlay_q) begin
            state_d = ST_DONE;
          end else if (idx_q == 6'd63) begin
            state_d = ST_OVL_LOAD;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = ST_LOAD;
          end
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      timer_q   <= '0;
      board_q   <= '0;
      crow_q    <= '0;
      ccol_q    <= '0;
      pending_q <= 1'b0;
      overlay_q <= 1'b0;
      busy_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      board_q   <= board_d;
      crow_q    <= crow_d;
      ccol_q    <= ccol_d;
      pending_q <= pending_d;
      overlay_q <= overlay_d;
      busy_q    <= busy_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sel_q     <= sel_d;
    end
  end

  assign x_out   = x_q;
  assign y_out   = y_q;
  assign select  = sel_q;
  assign busy    = busy_q;
  assign draw_en = (state_q == ST_FIRE);
  assign done    = (state_q == ST_DONE);

endmodule
